// File: rtl/led_fade_ctrl.sv
// Slew-rate limiter between the encoder value registers and the RGB PWM levels.
// Ramps each channel toward its target once per prescaler tick; blank fades all three to dark.
module led_fade_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 256,
  parameter int unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target0,
  input  logic [WIDTH-1:0] target1,
  input  logic [WIDTH-1:0] target2,
  input  logic             fade_en,
  input  logic             blank,
  output logic [WIDTH-1:0] level0,
  output logic [WIDTH-1:0] level1,
  output logic [WIDTH-1:0] level2,
  output logic             busy,
  output logic             dark,
  output logic             done
);

  localparam int unsigned     CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

  typedef enum logic [1:0] {
    SETTLED,
    RAMPING,
    FADING_OUT,
    DARK
  } state_e;

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick;
  logic             stepping;
  logic             match;
  logic [WIDTH-1:0] tgt   [3];
  logic [WIDTH-1:0] eff   [3];
  logic [WIDTH-1:0] lvl_q [3];
  logic [WIDTH-1:0] lvl_d [3];

  // Moves cur toward goal by at most STEP; clamps to goal so it never overshoots or wraps.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] goal);
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    res = cur;
    if (cur < goal) begin
      diff = goal - cur;
      res  = (diff > STEP_W) ? cur + STEP_W : goal;
    end else if (cur > goal) begin
      diff = cur - goal;
      res  = (diff > STEP_W) ? cur - STEP_W : goal;
    end
    return res;
  endfunction

  assign tgt[0] = target0;
  assign tgt[1] = target1;
  assign tgt[2] = target2;

  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      eff[c] = blank ? '0 : tgt[c];
    end
  end

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  assign match = (lvl_q[0] == eff[0]) && (lvl_q[1] == eff[1]) && (lvl_q[2] == eff[2]);

  assign stepping = fade_en && tick && ((state_q == RAMPING) || (state_q == FADING_OUT));

  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      lvl_d[c] = lvl_q[c];
      if (!fade_en) begin
        lvl_d[c] = eff[c];
      end else if (stepping) begin
        lvl_d[c] = step_toward(lvl_q[c], eff[c]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (!fade_en) begin
      state_d = blank ? DARK : SETTLED;
    end else begin
      case (state_q)
        SETTLED: begin
          if (blank) begin
            state_d = match ? DARK : FADING_OUT;
          end else if (!match) begin
            state_d = RAMPING;
          end
        end
        RAMPING: begin
          if (blank) begin
            state_d = match ? DARK : FADING_OUT;
          end else if (match) begin
            state_d = SETTLED;
            done_d  = 1'b1;
          end
        end
        FADING_OUT: begin
          // Releasing blank mid-fade is an abort, not a completion: no done pulse.
          if (!blank) begin
            state_d = match ? SETTLED : RAMPING;
          end else if (match) begin
            state_d = DARK;
            done_d  = 1'b1;
          end
        end
        DARK: begin
          if (!blank) begin
            state_d = match ? SETTLED : RAMPING;
          end
        end
        default: state_d = SETTLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SETTLED;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      for (int unsigned c = 0; c < 3; c++) begin
        lvl_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      for (int unsigned c = 0; c < 3; c++) begin
        lvl_q[c] <= lvl_d[c];
      end
    end
  end

  assign level0 = lvl_q[0];
  assign level1 = lvl_q[1];
  assign level2 = lvl_q[2];
  assign busy   = (state_q == RAMPING) || (state_q == FADING_OUT);
  assign dark   = (state_q == DARK);
  assign done   = done_q;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Scoreboard bench: three led_fade_ctrl instances (STEP 1/16/2, PRESCALE 4) share stimulus;
// a behavioural model predicts every cycle, plus directed checks of the key scenario values.
module tb_led_fade_ctrl;

  localparam int PRESC = 4;
  localparam int STEPS [3] = '{1, 16, 2};

  typedef struct packed {
    logic [7:0] l0;
    logic [7:0] l1;
    logic [7:0] l2;
    logic       busy;
    logic       dark;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tg0, tg1, tg2;
  logic       fade_en, blank;

  logic [7:0] lv0 [3];
  logic [7:0] lv1 [3];
  logic [7:0] lv2 [3];
  logic       bz  [3];
  logic       dk  [3];
  logic       dn  [3];

  int checks   = 0;
  int failures = 0;

  exp_t sb_q[$];

  int m_lvl [3][3];
  int m_st  [3];
  int m_dn  [3];
  int m_cnt = 0;

  int done_cnt [3];
  int chg_cnt    = 0;
  int busy_fall0 = 0;
  logic [7:0] prev_l1 = '0;
  logic       prev_b0 = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    led_fade_ctrl #(
      .WIDTH   (8),
      .PRESCALE(PRESC),
      .STEP    (STEPS[g])
    ) u_dut (
      .clk    (clk),
      .reset  (rst),
      .target0(tg0),
      .target1(tg1),
      .target2(tg2),
      .fade_en(fade_en),
      .blank  (blank),
      .level0 (lv0[g]),
      .level1 (lv1[g]),
      .level2 (lv2[g]),
      .busy   (bz[g]),
      .dark   (dk[g]),
      .done   (dn[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: signed delta clamped to +/-STEP, states 0=settled 1=ramp 2=fade 3=dark.
  always @(posedge clk) begin
    int   eff [3];
    int   d;
    int   st;
    bit   tick;
    bit   match;
    exp_t e;
    if (rst) begin
      m_cnt = 0;
      for (int g = 0; g < 3; g++) begin
        m_st[g] = 0;
        m_dn[g] = 0;
        for (int c = 0; c < 3; c++) m_lvl[g][c] = 0;
      end
    end else begin
      tick  = (m_cnt == PRESC - 1);
      m_cnt = (m_cnt + 1) % PRESC;
      eff[0] = blank ? 0 : int'(tg0);
      eff[1] = blank ? 0 : int'(tg1);
      eff[2] = blank ? 0 : int'(tg2);
      for (int g = 0; g < 3; g++) begin
        match = (m_lvl[g][0] == eff[0]) && (m_lvl[g][1] == eff[1]) && (m_lvl[g][2] == eff[2]);
        st = m_st[g];
        m_dn[g] = 0;
        if (!fade_en) begin
          for (int c = 0; c < 3; c++) m_lvl[g][c] = eff[c];
          m_st[g] = blank ? 3 : 0;
        end else begin
          if (tick && (st == 1 || st == 2)) begin
            for (int c = 0; c < 3; c++) begin
              d = eff[c] - m_lvl[g][c];
              if (d > STEPS[g]) d = STEPS[g];
              if (d < -STEPS[g]) d = -STEPS[g];
              m_lvl[g][c] = m_lvl[g][c] + d;
            end
          end
          case (st)
            0: if (blank) m_st[g] = match ? 3 : 2;
               else if (!match) m_st[g] = 1;
            1: if (blank) m_st[g] = match ? 3 : 2;
               else if (match) begin m_st[g] = 0; m_dn[g] = 1; end
            2: if (!blank) m_st[g] = match ? 0 : 1;
               else if (match) begin m_st[g] = 3; m_dn[g] = 1; end
            default: if (!blank) m_st[g] = match ? 0 : 1;
          endcase
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      e.l0   = 8'(m_lvl[g][0]);
      e.l1   = 8'(m_lvl[g][1]);
      e.l2   = 8'(m_lvl[g][2]);
      e.busy = (m_st[g] == 1) || (m_st[g] == 2);
      e.dark = (m_st[g] == 3);
      e.done = (m_dn[g] != 0);
      sb_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() >= 3) begin
      for (int g = 0; g < 3; g++) begin
        e = sb_q.pop_front();
        check_eq($sformatf("sb%0d.level0", g), lv0[g], e.l0);
        check_eq($sformatf("sb%0d.level1", g), lv1[g], e.l1);
        check_eq($sformatf("sb%0d.level2", g), lv2[g], e.l2);
        check_eq($sformatf("sb%0d.busy", g), bz[g], e.busy);
        check_eq($sformatf("sb%0d.dark", g), dk[g], e.dark);
        check_eq($sformatf("sb%0d.done", g), dn[g], e.done);
      end
    end
    for (int g = 0; g < 3; g++) if (dn[g]) done_cnt[g]++;
    if (lv1[1] != prev_l1) chg_cnt++;
    if (prev_b0 && !bz[0]) busy_fall0++;
    prev_l1 = lv1[1];
    prev_b0 = bz[0];
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int g = 0; g < 3; g++) done_cnt[g] = 0;
    chg_cnt    = 0;
    busy_fall0 = 0;
  endtask

  task automatic snap_to(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    tg0 = a; tg1 = b; tg2 = c;
    fade_en = 1'b0;
    cycles(2);
    fade_en = 1'b1;
    cycles(2);
  endtask

  initial begin
    int n;
    rst = 1'b1; fade_en = 1'b1; blank = 1'b0;
    tg0 = '0; tg1 = '0; tg2 = '0;
    cycles(3);
    check_eq("rst.level0", lv0[0], 0);
    check_eq("rst.busy", bz[0], 0);
    check_eq("rst.dark", dk[0], 0);
    check_eq("rst.done", dn[0], 0);

    // Basic ramp to 3
    clr_counts();
    rst = 1'b0; tg0 = 8'd3;
    cycles(24);
    check_eq("s1.level0", lv0[0], 3);
    check_eq("s1.done_cnt", done_cnt[0], 1);
    check_eq("s1.busy_end", bz[0], 0);

    // Large step, no overshoot
    snap_to(0, 0, 0);
    clr_counts();
    tg1 = 8'd200;
    cycles(70);
    check_eq("s2.up_level1", lv1[1], 200);
    check_eq("s2.up_steps", chg_cnt, 13);
    check_eq("s2.up_done", done_cnt[1], 1);
    clr_counts();
    tg1 = 8'd5;
    cycles(70);
    check_eq("s2.dn_level1", lv1[1], 5);
    check_eq("s2.dn_steps", chg_cnt, 13);
    check_eq("s2.dn_done", done_cnt[1], 1);

    // Mid-ramp reversal
    snap_to(0, 0, 0);
    clr_counts();
    tg2 = 8'd10;
    for (int i = 0; i < 40 && lv2[0] != 8'd4; i++) cycles(1);
    check_eq("s3.reach4", lv2[0], 4);
    tg2 = 8'd0;
    cycles(30);
    check_eq("s3.level2", lv2[0], 0);
    check_eq("s3.done_cnt", done_cnt[0], 1);
    check_eq("s3.busy_falls", busy_fall0, 1);

    // Blank fade and restore
    snap_to(8, 8, 8);
    clr_counts();
    blank = 1'b1;
    cycles(30);
    check_eq("s4.fade_l0", lv0[2], 0);
    check_eq("s4.fade_l2", lv2[2], 0);
    check_eq("s4.dark", dk[2], 1);
    check_eq("s4.fade_done", done_cnt[2], 1);
    blank = 1'b0;
    cycles(30);
    check_eq("s4.back_l1", lv1[2], 8);
    check_eq("s4.back_dark", dk[2], 0);
    check_eq("s4.back_done", done_cnt[2], 2);
    blank = 1'b1;
    cycles(30);
    blank = 1'b0;
    for (int i = 0; i < 40 && lv0[2] != 8'd4; i++) cycles(1);
    check_eq("s4.reach4", lv0[2], 4);
    for (int i = 0; i < 4 && m_cnt != PRESC - 1; i++) cycles(1);
    blank = 1'b1;
    cycles(1);
    check_eq("s4.tick_blank", lv0[2], 2);
    cycles(20);

    // Snap mode
    clr_counts();
    blank = 1'b0; fade_en = 1'b0; tg0 = 8'd255;
    cycles(1);
    check_eq("s5.snap_l0", lv0[0], 255);
    check_eq("s5.busy", bz[0], 0);
    blank = 1'b1;
    cycles(1);
    check_eq("s5.blank_l0", lv0[0], 0);
    check_eq("s5.dark", dk[0], 1);
    cycles(2);
    check_eq("s5.no_done", done_cnt[0], 0);

    // Reset mid-ramp
    blank = 1'b0;
    snap_to(0, 0, 0);
    tg1 = 8'd200;
    for (int i = 0; i < 600 && lv1[0] != 8'd100; i++) cycles(1);
    check_eq("s6.reach100", lv1[0], 100);
    rst = 1'b1;
    cycles(1);
    check_eq("s6.rst_l1", lv1[0], 0);
    check_eq("s6.rst_busy", bz[0], 0);
    check_eq("s6.rst_dark", dk[0], 0);
    check_eq("s6.rst_done", dn[0], 0);
    rst = 1'b0;
    n = 0;
    while (lv1[0] == 8'd0 && n < 20) begin
      cycles(1);
      n++;
    end
    check_eq("s6.first_tick", n, PRESC);
    cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
